prog_fetch: RTL and testbench
=============================

# prog_fetch

Instruction fetch unit that drives the program memory's 32-bit `PC` word address and consumes its combinational 32-bit `dataout`. Fetched words are queued, each tagged with its own PC, in a small buffer. The buffer hands them to decode over a valid/ready handshake. The unit also handles branch redirects and flags fetches outside the populated program space.

## Interface
- `RESET_PC`, 0: PC loaded at reset.
- `MEM_WORDS`, 256: number of program memory words; a PC at or above this is out of range.
- `DEPTH`, 2: instruction buffer entries (power of two, ≥2).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `PC`  out  32  word address to program memory.
- `instr_in`  in  32  program memory `dataout`, valid in the same cycle as `PC`.
- `fetch_en`  in  1  permits fetching; when low the PC holds.
- `redirect`  in  1  one-cycle branch/jump request.
- `redirect_pc`  in  32  target word address, sampled when `redirect`=1.
- `instr_out`  out  32  instruction at the buffer head.
- `instr_pc`  out  32  PC of `instr_out`.
- `instr_valid`  out  1  buffer non-empty.
- `instr_ready`  in  1  decode accepts the head this cycle.
- `fault`  out  1  out-of-range fetch attempted; sticky.

## Operation
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: `PC`=`RESET_PC`, buffer empty, `instr_valid`=0, `instr_out`=0, `instr_pc`=0, `fault`=0, state IDLE.
- States:
  - IDLE → FETCH when `fetch_en`=1. No capture occurs in IDLE.
  - FETCH → FAULT when a capture would occur with `PC` ≥ `MEM_WORDS`.
  - FETCH → IDLE when `fetch_en`=0.
  - FAULT → FETCH on `redirect` with `redirect_pc` < `MEM_WORDS`. This also clears `fault`.
  - FAULT stays in FAULT on `redirect` to an out-of-range target, but the PC still loads.
- Capture condition: state FETCH, `fetch_en`=1, `redirect`=0, `PC` < `MEM_WORDS`, and space available. Space is available when count < `DEPTH`, or count = `DEPTH` with `instr_valid` and `instr_ready` both high.
- Capture action: enqueue {`PC`, `instr_in`}, then `PC` ← `PC`+1 (32-bit modular).
- Dequeue: occurs when `instr_valid` and `instr_ready` are both 1. The head advances and `instr_out`/`instr_pc` show the next entry, or 0 when empty.
- Redirect has priority over everything:
  - Buffer flushed, `PC` ← `redirect_pc`, no capture that cycle.
  - A same-cycle handshake still counts as consumed by decode; remaining entries are discarded.
- `fetch_en`=0 in FETCH: no capture, `PC` holds, buffer drains normally.
- FAULT: no captures, `PC` frozen at the offending address, buffer drains, `fault`=1.

## Timing
- Capture at edge N of the word addressed by `PC` during cycle N−1; visible on `instr_out` after edge N.
- Latency: a `PC` value appears on `instr_pc` one cycle after it was presented.
- Throughput: one instruction per cycle with `instr_ready` held high.
- Startup: `fetch_en` rises in cycle 0 → FETCH at edge 1 → first capture at edge 2 → `instr_valid` high in cycle 2.
- Full buffer with `instr_ready`=0: `PC` stalls. Captures resume in the same cycle `instr_ready` rises (simultaneous enqueue and dequeue).
- Redirect asserted in cycle R: buffer empty and `PC`=target after edge R+1; first new instruction valid after edge R+2.
- `fault` rises on the edge where the out-of-range capture would have occurred.
- `rst_n` low mid-operation: all state returns immediately (asynchronously) to reset values. In-flight entries are lost.

## Structure
- Package `fetch_pkg`:
  - state encoding constants `ST_IDLE`, `ST_FETCH`, `ST_FAULT`;
  - default `MEM_WORDS`;
  - entry width constant (64 = PC + instruction).
- Sub-module `fetch_fifo`: `DEPTH`-entry synchronous FIFO with async active-low reset.
  - Ports: push, pop, flush, data in/out, count, full, empty.
  - Flush overrides push; pop and flush in the same cycle are legal.
- Top level holds the PC register, FSM, capture/space logic and fault flag.

## Test plan
Bench memory model: combinational, word i = 32'hA000_0000 + i for i < 256.
- Reset then `fetch_en`=1, `instr_ready`=1 → from cycle 2, `instr_out`=A000_0000, A000_0001, … one per cycle; `instr_pc`=0,1,2,…
- `instr_ready`=0 for 5 cycles after the first capture → `instr_valid` stays 1, `PC` stalls at 2 with 2 entries held. On release, A000_0000, A000_0001, then A000_0002 appear back-to-back with no bubble.
- Redirect to 0x40 while 2 entries are buffered and handshake active → head consumed, other entry dropped; next valid has `instr_out`=A000_0040, `instr_pc`=0x40, two edges later.
- Redirect to 0xFE, run → words FE and FF delivered, then `fault`=1 with `PC`=0x100 and no further captures. Redirect to 0x10 → `fault`=0, fetch resumes at A000_0010.
- `fetch_en` drops mid-stream → `PC` holds, buffer drains to `instr_valid`=0. Re-raising it resumes at the held PC after 2 cycles.
- `rst_n` pulsed low asynchronously while 2 entries are buffered → `instr_valid`, `fault`, `instr_out` and `instr_pc` go to 0 before the next clock edge; `PC`=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    localparam int unsigned MEM_WORDS_DEF = 256;
    localparam int unsigned ENTRY_W       = 64;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instruction} entries.
// Flush empties the queue and wins over a same-cycle push.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = ENTRY_W,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [AW:0]  count,
    output logic         full,
    output logic         empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign empty = (count == '0);
    assign full  = (count == (AW + 1)'(DEPTH));
    // Head reads as zero when empty so decode never sees stale entries.
    assign dout  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/prog_fetch.sv
// Instruction fetch unit: PC register, fetch FSM, capture/space logic and
// sticky out-of-range fault, feeding a small instruction buffer.
module prog_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEF,
    parameter int unsigned DEPTH     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] PC,
    input  logic [31:0] instr_in,
    input  logic        fetch_en,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        fault
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_e state;
    fetch_entry_t push_entry;
    fetch_entry_t head_entry;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          in_range;
    logic          space;
    logic          deq;
    logic          capture;

    assign in_range = (PC < MEM_WORDS);
    assign deq      = instr_valid && instr_ready;
    // A full buffer still has room when the head leaves in the same cycle.
    assign space    = (count < CW'(DEPTH)) || (full && deq);
    assign capture  = (state == ST_FETCH) && fetch_en && !redirect && in_range && space;

    assign push_entry = '{pc: PC, instr: instr_in};

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (capture),
        .pop   (deq),
        .flush (redirect),
        .din   (push_entry),
        .dout  (head_entry),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign instr_valid = !empty;
    assign instr_out   = head_entry.instr;
    assign instr_pc    = head_entry.pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            PC    <= RESET_PC;
            fault <= 1'b0;
        end else begin
            if (redirect) begin
                PC <= redirect_pc;
            end else if (capture) begin
                PC <= PC + 32'd1;
            end
            case (state)
                ST_IDLE: begin
                    if (fetch_en) state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (!fetch_en) begin
                        state <= ST_IDLE;
                    end else if (!redirect && !in_range && space) begin
                        state <= ST_FAULT;
                        fault <= 1'b1;
                    end
                end
                ST_FAULT: begin
                    if (redirect && (redirect_pc < MEM_WORDS)) begin
                        state <= ST_FETCH;
                        fault <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_fetch.sv
// Self-checking bench for prog_fetch: directed stimulus, expected deliveries
// queued in a scoreboard and compared by a handshake monitor.
module tb_prog_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_w;
    logic [31:0] instr_in;
    logic        fetch_en = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        fault;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    // Program memory model: word i = A000_0000 + i inside the populated space.
    assign instr_in = (pc_w < 32'd256) ? (32'hA000_0000 + pc_w) : 32'hDEAD_BEEF;

    prog_fetch #(
        .RESET_PC  (32'd0),
        .MEM_WORDS (256),
        .DEPTH     (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .PC          (pc_w),
        .instr_in    (instr_in),
        .fetch_en    (fetch_en),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .fault       (fault)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_word(input logic [31:0] p, input logic [31:0] w);
        sb.push_back({p, w});
    endtask

    task automatic do_reset();
        fetch_en    = 1'b0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        rst_n       = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
    endtask

    // Monitor: every handshake must match the oldest expected delivery.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && instr_valid && instr_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected actual pc=%h instr=%h required=none",
                             instr_pc, instr_out);
                end else begin
                    mon_e = sb.pop_front();
                    if (instr_pc !== mon_e.pc || instr_out !== mon_e.instr) begin
                        failures++;
                        $display("FAIL sb_delivery actual pc=%h instr=%h required pc=%h instr=%h",
                                 instr_pc, instr_out, mon_e.pc, mon_e.instr);
                    end
                end
            end
        end
    end

    initial begin
        // Reset values
        step(2);
        check("rst_pc", pc_w, 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_instr_out", instr_out, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        rst_n = 1'b1;
        step();

        // Streaming, fetch_en drop and resume
        fetch_en    = 1'b1;
        instr_ready = 1'b1;
        expect_word(32'd0, 32'hA000_0000);
        expect_word(32'd1, 32'hA000_0001);
        expect_word(32'd2, 32'hA000_0002);
        expect_word(32'd3, 32'hA000_0003);
        expect_word(32'd4, 32'hA000_0004);
        expect_word(32'd5, 32'hA000_0005);
        expect_word(32'd6, 32'hA000_0006);
        step();
        check("start_valid_e1", 32'(instr_valid), 32'd0);
        step();
        check("start_valid_e2", 32'(instr_valid), 32'd1);
        check("start_instr_pc", instr_pc, 32'd0);
        check("start_instr_out", instr_out, 32'hA000_0000);
        step(4);
        check("stream_pc", pc_w, 32'd5);
        fetch_en = 1'b0;
        step();
        check("drain_valid", 32'(instr_valid), 32'd0);
        check("drain_pc", pc_w, 32'd5);
        step(2);
        check("hold_pc", pc_w, 32'd5);
        fetch_en = 1'b1;
        step();
        check("resume_valid_e1", 32'(instr_valid), 32'd0);
        step();
        check("resume_valid_e2", 32'(instr_valid), 32'd1);
        check("resume_instr_pc", instr_pc, 32'd5);
        step();
        fetch_en = 1'b0;
        step(2);
        check("a_end_valid", 32'(instr_valid), 32'd0);
        check("a_end_pc", pc_w, 32'd7);
        check("a_sb_drained", 32'(sb.size()), 32'd0);

        // Stall, redirect with handshake, fault and recovery
        do_reset();
        fetch_en    = 1'b1;
        instr_ready = 1'b0;
        expect_word(32'd0, 32'hA000_0000);
        expect_word(32'd1, 32'hA000_0001);
        expect_word(32'd2, 32'hA000_0002);
        expect_word(32'h40, 32'hA000_0040);
        expect_word(32'h41, 32'hA000_0041);
        expect_word(32'hFE, 32'hA000_00FE);
        expect_word(32'hFF, 32'hA000_00FF);
        expect_word(32'h10, 32'hA000_0010);
        step(2);
        check("stall_first_valid", 32'(instr_valid), 32'd1);
        step(4);
        check("stall_pc", pc_w, 32'd2);
        check("stall_valid", 32'(instr_valid), 32'd1);
        check("stall_head_pc", instr_pc, 32'd0);
        step();
        instr_ready = 1'b1;
        step();
        check("release_head1", instr_pc, 32'd1);
        step();
        check("release_head2", instr_pc, 32'd2);
        check("release_pc", pc_w, 32'd4);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        step();
        redirect = 1'b0;
        check("redir_flush_valid", 32'(instr_valid), 32'd0);
        check("redir_pc", pc_w, 32'h40);
        step();
        check("redir_new_valid", 32'(instr_valid), 32'd1);
        check("redir_new_pc", instr_pc, 32'h40);
        check("redir_new_instr", instr_out, 32'hA000_0040);
        step();
        redirect    = 1'b1;
        redirect_pc = 32'hFE;
        step();
        redirect = 1'b0;
        step(2);
        check("edge_fault_low", 32'(fault), 32'd0);
        check("edge_pc", pc_w, 32'h100);
        step();
        check("fault_set", 32'(fault), 32'd1);
        check("fault_pc", pc_w, 32'h100);
        check("fault_valid", 32'(instr_valid), 32'd0);
        step(2);
        check("fault_hold_fault", 32'(fault), 32'd1);
        check("fault_hold_pc", pc_w, 32'h100);
        check("fault_hold_valid", 32'(instr_valid), 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        step();
        redirect = 1'b0;
        check("fault_oor_redir_pc", pc_w, 32'h200);
        check("fault_oor_redir_fault", 32'(fault), 32'd1);
        step();
        check("fault_oor_valid", 32'(instr_valid), 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h10;
        step();
        redirect = 1'b0;
        check("recover_fault", 32'(fault), 32'd0);
        check("recover_pc", pc_w, 32'h10);
        step();
        check("recover_valid", 32'(instr_valid), 32'd1);
        check("recover_instr", instr_out, 32'hA000_0010);
        fetch_en = 1'b0;
        step(2);
        check("b_end_valid", 32'(instr_valid), 32'd0);
        check("b_sb_drained", 32'(sb.size()), 32'd0);

        // Asynchronous reset with two buffered entries
        do_reset();
        fetch_en    = 1'b1;
        instr_ready = 1'b0;
        step(3);
        check("pre_areset_valid", 32'(instr_valid), 32'd1);
        check("pre_areset_pc", pc_w, 32'd2);
        #3;
        rst_n = 1'b0;
        #1;
        check("areset_valid", 32'(instr_valid), 32'd0);
        check("areset_fault", 32'(fault), 32'd0);
        check("areset_instr_out", instr_out, 32'd0);
        check("areset_instr_pc", instr_pc, 32'd0);
        check("areset_pc", pc_w, 32'd0);
        #2;
        rst_n = 1'b1;
        fetch_en = 1'b0;
        step(2);
        check("final_sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
